mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 multiplexer built as a binary tree of 2:1 stages, with one register level per tree level, a valid/ready handshake and a self-incrementing scan mode. It is the generalised successor to the team's fixed 16:1 combinational tree. It is intended for channel selection and time-division readout of multi-channel data buses where the combinational tree depth would limit clock rate.

## Interface
Parameters:
- WIDTH, 8, data bits per channel (≥1)
- SEL_BITS, 4, select width; channel count N = 2**SEL_BITS (1..6)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  N*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts beat this cycle
- sel  input  SEL_BITS  channel select, used when mode=0
- mode  input  1  0 = external select, 1 = scan
- out_data  output  WIDTH  selected channel word
- out_sel  output  SEL_BITS  channel number that out_data came from
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts beat
- scan_wrap  output  1  high with the output beat of channel N-1 when it was issued in scan mode

## Operation
- Effective select: eff_sel = sel when mode=0, scan_cnt when mode=1.
- Tree level k (k = 0..SEL_BITS-1) reduces N/2**k words to N/2**(k+1) words. Pair j selects word 2j+1 if eff_sel bit k = 1, else word 2j. Select bits are consumed LSB-first, and bit k is applied at level k.
- Each level registers its reduced words, a valid bit, the full eff_sel (becomes out_sel), and a scan flag. The last level drives out_data, out_sel, out_valid, scan_wrap directly from its registers.
- Global stall: stall = out_valid & ~out_ready. in_ready = ~stall. When stalled, every pipeline register holds, including bubbles. Stages do not compact.
- Accept = in_valid & in_ready. When not stalled, level 0 loads its valid bit with in_valid, so a bubble enters the pipeline when in_valid=0.
- scan_cnt (SEL_BITS bits):
  - cleared to 0 whenever mode=0.
  - when mode=1 and accept, it increments, wrapping from N-1 to 0.
  - it does not change on cycles without accept.
- scan_wrap = out_valid & (out_sel = N-1) & scan flag of that beat.
- Mode changes take effect on the next accepted beat. Beats already in flight keep the select captured at acceptance.
- Arithmetic: scan_cnt wraps modulo N naturally. No other arithmetic is performed.

## Timing
- Latency: SEL_BITS cycles from accept to out_valid, with no stall.
- Throughput: one beat per cycle while out_ready=1.
- Reset (async assert, sync release by system):
  - all valid bits = 0, out_valid = 0, scan_wrap = 0
  - out_data = 0, out_sel = 0, scan_cnt = 0
  - in_ready = 1
- Reset asserted mid-stream discards all in-flight beats immediately. No partial output is produced after release.
- in_ready depends combinationally on out_valid and out_ready only. It never depends on in_valid.
- Simultaneous mode 1→0 and accept: the beat uses sel, and scan_cnt clears.
- Simultaneous mode 0→1 and accept: the beat uses scan_cnt = 0, and scan_cnt becomes 1.
- SEL_BITS=1 degenerates to a single registered 2:1 stage with latency 1.

## Test plan
All scenarios use WIDTH=8, SEL_BITS=4, and channel c data = 8'h10+c unless noted.
- Reset: assert rst mid-stream with 3 beats in flight, then release. Required: out_valid=0 immediately; no output beat until 4 cycles after the next accept; in_ready=1.
- External select sweep: mode=0, sel=11 (4'b1011) for one beat. Required: out_data=8'h1B and out_sel=11, 4 cycles later. A back-to-back sel sequence 0..15 gives out_data 8'h10..8'h1F on consecutive cycles.
- Scan mode: mode=1, in_valid=1 for 20 cycles. Required:
  - out_sel runs 0..15 then 0..3.
  - scan_wrap=1 only on the beat with out_sel=15.
- Backpressure: out_ready low for 5 cycles in the middle of a streaming run. Required:
  - out_data holds its value.
  - in_ready=0 for exactly those stalled cycles.
  - no beat is lost or duplicated, and sequence order is preserved.
- Bubbles: in_valid pattern 1,0,1,1,0 with sel=2,x,5,7,x. Required: out_valid pattern 1,0,1,1,0 with out_data 8'h12, 8'h15, 8'h17, starting 4 cycles later.
- Mode switch: mode=1 for 3 accepts, then mode=0 with sel=9, then mode=1 again. Required:
  - outputs are channels 0,1,2, then 9, then 0.
  - scan_wrap=0 throughout.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// Handshake and data bundle for mux_tree_pipe: N-channel input bus in, one
// selected channel word out, valid/ready on both sides.
interface mux_tree_pipe_if #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 4
);
  localparam int N = 1 << SEL_BITS;

  logic [N*WIDTH-1:0]  in_data;
  logic                in_valid;
  logic                in_ready;
  logic [SEL_BITS-1:0] sel;
  logic                mode;
  logic [WIDTH-1:0]    out_data;
  logic [SEL_BITS-1:0] out_sel;
  logic                out_valid;
  logic                out_ready;
  logic                scan_wrap;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_sel, out_valid, scan_wrap
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_sel, out_valid, scan_wrap
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux tree, one register level per 2:1 tree level, with a
// global-stall valid/ready handshake and an auto-incrementing scan select.
module mux_tree_pipe #(
  parameter int WIDTH    = 8,
  parameter int SEL_BITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_tree_pipe_if.slave bus
);
  localparam int N = 1 << SEL_BITS;

  // Level k words are packed into one node array starting at N - (N >> k);
  // level k holds N >> (k+1) words and the root sits at index N-2.
  function automatic int lvl_off(input int k);
    return N - (N >> k);
  endfunction

  logic [WIDTH-1:0]    r_node [0:N-2];
  logic [WIDTH-1:0]    w_node_next [0:N-2];
  logic [SEL_BITS-1:0] r_sel [SEL_BITS];
  logic [SEL_BITS-1:0] r_valid;
  logic [SEL_BITS-1:0] r_scan;
  logic [SEL_BITS-1:0] r_scan_cnt;

  logic                w_stall;
  logic                w_accept;
  logic [SEL_BITS-1:0] w_eff_sel;

  assign w_stall   = bus.out_valid & ~bus.out_ready;
  assign w_accept  = bus.in_valid & ~w_stall;
  assign w_eff_sel = bus.mode ? r_scan_cnt : bus.sel;

  always_comb begin
    // NOTE: defaulting the whole array first keeps every element assigned on
    // every path, so no latch is inferred for the loop-written entries.
    w_node_next = r_node;
    for (int j = 0; j < N / 2; j++) begin
      w_node_next[j] = w_eff_sel[0] ? bus.in_data[(2*j+1)*WIDTH +: WIDTH]
                                    : bus.in_data[(2*j)*WIDTH +: WIDTH];
    end
    // Each beat carries its own select, so level k uses the select bit of the
    // beat currently held in level k-1.
    for (int k = 1; k < SEL_BITS; k++) begin
      for (int j = 0; j < (N >> (k + 1)); j++) begin
        w_node_next[lvl_off(k) + j] = r_sel[k-1][k] ? r_node[lvl_off(k-1) + 2*j + 1]
                                                    : r_node[lvl_off(k-1) + 2*j];
      end
    end
  end

  // NOTE: the data tree is reset along with the control bits so out_data
  // reads zero after reset rather than stale channel data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_node  <= '{default: '0};
      r_sel   <= '{default: '0};
      r_valid <= '0;
      r_scan  <= '0;
    end else if (!w_stall) begin
      // NOTE: non-blocking assignments let every level read the previous
      // level's old value, giving a true one-cycle shift per level.
      r_node     <= w_node_next;
      r_valid[0] <= bus.in_valid;
      r_scan[0]  <= bus.mode;
      r_sel[0]   <= w_eff_sel;
      for (int k = 1; k < SEL_BITS; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_scan[k]  <= r_scan[k-1];
        r_sel[k]   <= r_sel[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
    end else if (!bus.mode) begin
      r_scan_cnt <= '0;
    end else if (w_accept) begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = ~w_stall;
  assign bus.out_data  = r_node[N-2];
  assign bus.out_sel   = r_sel[SEL_BITS-1];
  assign bus.out_valid = r_valid[SEL_BITS-1];
  assign bus.scan_wrap = r_valid[SEL_BITS-1] & r_scan[SEL_BITS-1]
                       & (r_sel[SEL_BITS-1] == {SEL_BITS{1'b1}});
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed self-checking bench for mux_tree_pipe (WIDTH=8, SEL_BITS=4),
// channel c carries 8'h10+c.
module tb_mux_tree_pipe;
  localparam int WIDTH    = 8;
  localparam int SEL_BITS = 4;
  localparam int N        = 1 << SEL_BITS;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  mux_tree_pipe_if #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus ();

  mux_tree_pipe #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic m);
    bus.in_valid = v;
    bus.sel      = s;
    bus.mode     = m;
  endtask

  // Hand-computed tables for the bubble and mode-switch scenarios.
  logic       bub_v    [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] bub_s    [5] = '{4'd2, 4'd0, 4'd5, 4'd7, 4'd0};
  logic [7:0] bub_d    [5] = '{8'h12, 8'h00, 8'h15, 8'h17, 8'h00};
  logic       ms_mode  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] ms_sel   [5] = '{4'd0, 4'd0, 4'd0, 4'd9, 4'd0};
  logic [3:0] ms_esel  [5] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd0};
  logic [7:0] ms_edata [5] = '{8'h10, 8'h11, 8'h12, 8'h19, 8'h10};

  initial begin
    int send;
    int rcv;
    int b;

    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 1'b0);
    for (int c = 0; c < N; c++) bus.in_data[c*WIDTH +: WIDTH] = 8'(8'h10 + c);
    #3;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check("rst_scan_wrap", 32'(bus.scan_wrap), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    step();
    rst = 1'b0;
    step();

    // Single beat, sel=11: visible exactly 4 edges after acceptance.
    drive(1'b1, 4'd11, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    step();
    step();
    check("single_early_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_data",  32'(bus.out_data),  32'h1B);
    check("single_sel",   32'(bus.out_sel),   32'd11);
    step();
    check("single_after", 32'(bus.out_valid), 32'd0);

    // Back-to-back external sweep 0..15.
    for (int i = 0; i < 19; i++) begin
      drive(i < 16, 4'(i), 1'b0);
      step();
      if (i >= 3) begin
        check("sweep_valid", 32'(bus.out_valid), 32'd1);
        check("sweep_data",  32'(bus.out_data),  32'(8'h10 + (i - 3)));
      end
    end
    drive(1'b0, 4'd0, 1'b0);
    step();

    // Scan mode for 20 beats.
    for (int i = 0; i < 23; i++) begin
      drive(i < 20, 4'd0, 1'b1);
      step();
      if (i >= 3) begin
        b = i - 3;
        check("scan_valid", 32'(bus.out_valid), 32'd1);
        check("scan_sel",   32'(bus.out_sel),   32'(b % 16));
        check("scan_data",  32'(bus.out_data),  32'(8'h10 + (b % 16)));
        check("scan_wrap",  32'(bus.scan_wrap), 32'(b == 15));
      end
    end
    drive(1'b0, 4'd0, 1'b0);
    step();
    check("scan_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: out_ready low for cycles 10..14 of a 20-beat stream.
    send = 0;
    rcv  = 0;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = !(c >= 10 && c <= 14);
      drive(send < 20, 4'(send % 16), 1'b0);
      #1;
      if (c >= 4 && c <= 20)
        check("bp_in_ready", 32'(bus.in_ready), 32'(!(c >= 10 && c <= 14)));
      if (c >= 10 && c <= 14) begin
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data",  32'(bus.out_data),  32'(8'h10 + (rcv % 16)));
      end
      if (bus.out_valid && bus.out_ready) begin
        check("bp_order", 32'(bus.out_data), 32'(8'h10 + (rcv % 16)));
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) send++;
      step();
    end
    check("bp_count", 32'(rcv), 32'd20);
    bus.out_ready = 1'b1;
    drive(1'b0, 4'd0, 1'b0);

    // Bubbles in the input stream pass through in place.
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(bub_v[i], bub_s[i], 1'b0);
      else       drive(1'b0, 4'd0, 1'b0);
      step();
      if (i >= 3) begin
        check("bub_valid", 32'(bus.out_valid), 32'(bub_v[i-3]));
        if (bub_v[i-3]) check("bub_data", 32'(bus.out_data), 32'(bub_d[i-3]));
      end
    end

    // Mode switching on accepted beats.
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, ms_sel[i], ms_mode[i]);
      else       drive(1'b0, 4'd0, 1'b0);
      step();
      if (i >= 3) begin
        check("ms_valid", 32'(bus.out_valid), 32'd1);
        check("ms_sel",   32'(bus.out_sel),   32'(ms_esel[i-3]));
        check("ms_data",  32'(bus.out_data),  32'(ms_edata[i-3]));
        check("ms_wrap",  32'(bus.scan_wrap), 32'd0);
      end
    end
    step();

    // Reset asserted mid-stream with beats in flight.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'(i + 1), 1'b0);
      step();
    end
    check("mid_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",  32'(bus.out_data),  32'h0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'd1);
    drive(1'b0, 4'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end
    drive(1'b1, 4'd6, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    step();
    check("post_rst_lat1", 32'(bus.out_valid), 32'd0);
    step();
    check("post_rst_lat2", 32'(bus.out_valid), 32'd0);
    step();
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_data",  32'(bus.out_data),  32'h16);
    check("post_rst_ready", 32'(bus.in_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
